// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup for the fetch PC; trained on resolved control transfers from EX.
module btb_predictor #(
  parameter int unsigned ENTRIES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        hit_o,
  output logic [31:0] predicted_pc_o,
  input  logic        flush_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_taken_i,
  output logic [31:0] mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  localparam logic [1:0] CtrReset = 2'b01;
  localparam logic [1:0] CtrAlloc = 2'b10;
  localparam logic [1:0] CtrMax   = 2'b11;
  localparam logic [1:0] CtrMin   = 2'b00;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [29:0]      r_tgt   [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];
  logic [31:0]      r_mispredict_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic [29:0]      w_up_tgt;
  logic             w_up_match;
  logic             w_up_pred;
  logic             w_mispredict;
  logic [1:0]       w_ctr_next;
  logic             w_do_update;
  logic             w_write_tgt;

  // Low address bits carry no information for word-aligned fetch.
  logic w_unused;
  assign w_unused = ^{pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

  // Lookup: purely combinational from registered state.
  always_comb begin
    w_lk_idx = pc_i[IDX_W+1:2];
    w_lk_tag = pc_i[31:IDX_W+2];
    w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && r_ctr[w_lk_idx][1];
  end

  assign hit_o            = w_lk_hit;
  assign predicted_pc_o   = w_lk_hit ? {r_tgt[w_lk_idx], 2'b00} : 32'h0;
  assign mispredict_cnt_o = r_mispredict_cnt;

  // Update decode, evaluated against pre-update state.
  always_comb begin
    w_up_idx     = upd_pc_i[IDX_W+1:2];
    w_up_tag     = upd_pc_i[31:IDX_W+2];
    w_up_tgt     = upd_target_i[31:2];
    w_up_match   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    w_up_pred    = w_up_match && r_ctr[w_up_idx][1];
    w_mispredict = (w_up_pred != upd_taken_i) ||
                   (w_up_pred && (r_tgt[w_up_idx] != w_up_tgt));
    w_ctr_next   = r_ctr[w_up_idx];
    if (upd_taken_i) begin
      if (r_ctr[w_up_idx] != CtrMax) w_ctr_next = r_ctr[w_up_idx] + 2'd1;
    end else begin
      if (r_ctr[w_up_idx] != CtrMin) w_ctr_next = r_ctr[w_up_idx] - 2'd1;
    end
    w_do_update  = upd_valid_i && !rst_i && !flush_i;
    // Both a taken hit and a taken miss (allocation) write tag and target.
    w_write_tgt  = w_do_update && upd_taken_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CtrReset;
      end
      r_mispredict_cnt <= 32'h0;
    end else if (flush_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CtrReset;
      end
    end else if (upd_valid_i) begin
      if (w_up_match) begin
        r_ctr[w_up_idx] <= w_ctr_next;
      end else if (upd_taken_i) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= CtrAlloc;
      end
      if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  // Tag and target storage carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (w_write_tgt) begin
      r_tag[w_up_idx] <= w_up_tag;
      r_tgt[w_up_idx] <= w_up_tgt;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized bench for btb_predictor: behavioural table model checked every cycle at negedge,
// plus directed sequences with literal expectations.
module tb_btb_predictor;

  localparam int unsigned ENTRIES = 32;
  localparam int unsigned IDX_W   = 5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        hit_o;
  logic [31:0] predicted_pc_o;
  logic        flush_i = 1'b0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = 32'h0;
  logic [31:0] upd_target_i = 32'h0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] mispredict_cnt_o;

  btb_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .hit_o            (hit_o),
    .predicted_pc_o   (predicted_pc_o),
    .flush_i          (flush_i),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_target_i     (upd_target_i),
    .upd_taken_i      (upd_taken_i),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference table: one slot per index, plain integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_cnt = 0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int unsigned i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_pred(input logic [31:0] pc);
    if (!model_hit(pc)) return 32'h0;
    return m_tgt[idx_of(pc)] << 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state advances on the same edge the DUT samples.
  always @(posedge clk_i) begin
    int unsigned i;
    bit          pred;
    bit          match;
    if (rst_i) begin
      for (int k = 0; k < int'(ENTRIES); k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
      m_cnt = 0;
    end else if (flush_i) begin
      for (int k = 0; k < int'(ENTRIES); k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (upd_valid_i) begin
      i     = idx_of(upd_pc_i);
      match = m_valid[i] && (m_tag[i] == tag_of(upd_pc_i));
      pred  = model_hit(upd_pc_i);
      if ((pred != upd_taken_i) || (pred && m_tgt[i] != (upd_target_i >> 2))) m_cnt = m_cnt + 1;
      if (match) begin
        if (upd_taken_i) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target_i >> 2;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken_i) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upd_pc_i);
        m_tgt[i]   = upd_target_i >> 2;
        m_ctr[i]   = 2;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("model_hit", {31'h0, hit_o}, {31'h0, model_hit(pc_i)});
      check("model_pred", predicted_pc_o, model_pred(pc_i));
      check("model_cnt", mispredict_cnt_o, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit tk);
    upd_valid_i  = v;
    upd_pc_i     = pc;
    upd_target_i = tgt;
    upd_taken_i  = tk;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    // Reset with a fetch of 0x40.
    rst_i = 1'b1;
    pc_i  = 32'h40;
    cyc();
    rst_i  = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_hit", {31'h0, hit_o}, 32'h0);
    check("rst_pred", predicted_pc_o, 32'h0);
    check("rst_cnt", mispredict_cnt_o, 32'h0);

    // Same-cycle lookup sees the pre-update (empty) entry.
    set_upd(1'b1, 32'h40, 32'h200, 1'b1);
    #1;
    check("same_cycle_hit", {31'h0, hit_o}, 32'h0);
    cyc();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("alloc_hit", {31'h0, hit_o}, 32'h1);
    check("alloc_pred", predicted_pc_o, 32'h200);
    check("alloc_cnt", mispredict_cnt_o, 32'h1);

    // Not taken: 10 -> 01, stops predicting.
    set_upd(1'b1, 32'h40, 32'h200, 1'b0);
    cyc();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("nt_hit", {31'h0, hit_o}, 32'h0);
    check("nt_cnt", mispredict_cnt_o, 32'h2);

    // Taken twice: 01 -> 10 (mispredict) -> 11 (correct).
    set_upd(1'b1, 32'h40, 32'h200, 1'b1);
    cyc();
    cyc();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("tt_hit", {31'h0, hit_o}, 32'h1);
    check("tt_pred", predicted_pc_o, 32'h200);
    check("tt_cnt", mispredict_cnt_o, 32'h3);

    // Aliasing PC 0xC0 shares the index with 0x40.
    pc_i = 32'hC0;
    #1;
    check("alias_miss", {31'h0, hit_o}, 32'h0);
    set_upd(1'b1, 32'hC0, 32'h300, 1'b1);
    cyc();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("alias_hit", {31'h0, hit_o}, 32'h1);
    check("alias_pred", predicted_pc_o, 32'h300);
    check("alias_cnt", mispredict_cnt_o, 32'h4);
    pc_i = 32'h40;
    #1;
    check("alias_evict", {31'h0, hit_o}, 32'h0);

    // Flush wins over a concurrent update; counter kept.
    flush_i = 1'b1;
    set_upd(1'b1, 32'h40, 32'h500, 1'b1);
    cyc();
    flush_i = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("flush_hit40", {31'h0, hit_o}, 32'h0);
    pc_i = 32'hC0;
    #1;
    check("flush_hitC0", {31'h0, hit_o}, 32'h0);
    check("flush_cnt", mispredict_cnt_o, 32'h4);

    // Randomized traffic over a small aliasing address pool.
    for (int n = 0; n < 3000; n++) begin
      pc_i    = rand_pc();
      rst_i   = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 49) == 0);
      set_upd($urandom_range(0, 9) < 7,
              ($urandom_range(0, 3) == 0) ? pc_i : rand_pc(),
              ($urandom_range(0, 1) == 0) ? {24'h0, 8'($urandom_range(0, 3) << 4)} : $urandom,
              $urandom_range(0, 9) < 6);
      cyc();
    end
    rst_i   = 1'b0;
    flush_i = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    cyc();
    @(negedge clk_i);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
